// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, drives the instruction ROM address,
// computes next-PC with delay-slot semantics and registers the IF/ID stage.
// An out-of-range or misaligned next PC freezes fetch in a sticky HALT state.
module instr_fetch_unit #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter int          ADRBITS  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [1:0]  npc_sel,
    input  logic [15:0] br_off16,
    input  logic [25:0] j_imm26,
    input  logic [31:0] jr_target,
    output logic [31:0] imem_pc,
    input  logic [31:0] imem_instr,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc8,
    output logic        id_valid,
    output logic        fault,
    output logic [31:0] fault_pc
);

    // One past the last legal word; 33 bits so the bound cannot wrap.
    localparam logic [32:0] PC_END = {1'b0, PC_RESET} + (33'd4 << ADRBITS);

    typedef enum logic [1:0] {S_BOOT, S_RUN, S_HALT} state_t;

    state_t      r_state, w_state_nxt;
    logic [31:0] r_pc, r_id_instr, r_id_pc, r_fault_pc;
    logic        r_id_valid, r_fault;

    logic [31:0] w_pc_nxt, w_id_instr_nxt, w_id_pc_nxt, w_fault_pc_nxt;
    logic        w_id_valid_nxt, w_fault_nxt;
    logic [31:0] w_idpc4, w_br, w_jmp, w_next;
    logic        w_bad;

    // Redirect targets are relative to the instruction sitting in ID; the
    // jump keeps the upper nibble of that instruction's PC + 4.
    assign w_idpc4 = r_id_pc + 32'd4;
    assign w_br    = w_idpc4 + {{14{br_off16[15]}}, br_off16, 2'b00};
    assign w_jmp   = {w_idpc4[31:28], j_imm26, 2'b00};

    // Next-PC select and legality check of the chosen address.
    always_comb begin
        w_next = r_pc + 32'd4;
        case (npc_sel)
            2'd1:    w_next = w_br;
            2'd2:    w_next = w_jmp;
            2'd3:    w_next = jr_target;
            default: w_next = r_pc + 32'd4;
        endcase
        w_bad = (w_next[1:0] != 2'b00) || (w_next < PC_RESET) ||
                ({1'b0, w_next} >= PC_END);
    end

    // Next-state and next-register values; everything holds by default.
    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_id_instr_nxt = r_id_instr;
        w_id_pc_nxt    = r_id_pc;
        w_id_valid_nxt = r_id_valid;
        w_fault_nxt    = r_fault;
        w_fault_pc_nxt = r_fault_pc;
        case (r_state)
            S_BOOT: w_state_nxt = S_RUN;
            S_RUN: begin
                // While stalled the ID-stage redirect is not final: pure hold.
                if (!stall) begin
                    // The word fetched this cycle is the delay slot; never flushed.
                    w_id_instr_nxt = imem_instr;
                    w_id_pc_nxt    = r_pc;
                    w_id_valid_nxt = 1'b1;
                    if (w_bad) begin
                        w_fault_nxt    = 1'b1;
                        w_fault_pc_nxt = w_next;
                        w_state_nxt    = S_HALT;
                    end else begin
                        w_pc_nxt = w_next;
                    end
                end
            end
            S_HALT: begin
                w_id_instr_nxt = 32'd0;
                w_id_valid_nxt = 1'b0;
            end
            default: w_state_nxt = S_BOOT;
        endcase
    end

    // State and pipeline registers; reset has priority over everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_BOOT;
            r_pc       <= PC_RESET;
            r_id_instr <= 32'd0;
            r_id_pc    <= PC_RESET;
            r_id_valid <= 1'b0;
            r_fault    <= 1'b0;
            r_fault_pc <= 32'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_id_instr <= w_id_instr_nxt;
            r_id_pc    <= w_id_pc_nxt;
            r_id_valid <= w_id_valid_nxt;
            r_fault    <= w_fault_nxt;
            r_fault_pc <= w_fault_pc_nxt;
        end
    end

    assign imem_pc  = r_pc;
    assign id_instr = r_id_instr;
    assign id_pc    = r_id_pc;
    assign id_pc8   = r_id_pc + 32'd8;
    assign id_valid = r_id_valid;
    assign fault    = r_fault;
    assign fault_pc = r_fault_pc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a combinational ROM model whose
// word at index i is 32'h1111_1111 * (i + 1).
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset, stall;
    logic [1:0]  npc_sel;
    logic [15:0] br_off16;
    logic [25:0] j_imm26;
    logic [31:0] jr_target, imem_pc, imem_instr;
    logic [31:0] id_instr, id_pc, id_pc8, fault_pc;
    logic        id_valid, fault;

    int n_vec = 0;
    int n_err = 0;

    instr_fetch_unit dut (
        .clk(clk), .reset(reset), .stall(stall), .npc_sel(npc_sel),
        .br_off16(br_off16), .j_imm26(j_imm26), .jr_target(jr_target),
        .imem_pc(imem_pc), .imem_instr(imem_instr), .id_instr(id_instr),
        .id_pc(id_pc), .id_pc8(id_pc8), .id_valid(id_valid),
        .fault(fault), .fault_pc(fault_pc)
    );

    always #5 clk = ~clk;

    assign imem_instr = 32'h1111_1111 * ({22'd0, imem_pc[11:2]} + 32'd1);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; npc_sel = 2'd0;
        br_off16 = 16'd0; j_imm26 = 26'd0; jr_target = 32'd0;

        // Reset held two cycles
        tick(); tick();
        chk("rst_pc", imem_pc, 32'h0000_3000);
        chk("rst_idpc", id_pc, 32'h0000_3000);
        chk("rst_valid", {31'd0, id_valid}, 32'd0);
        chk("rst_instr", id_instr, 32'd0);
        chk("rst_fault", {31'd0, fault}, 32'd0);
        chk("rst_fpc", fault_pc, 32'd0);

        // BOOT edge: PC held, nothing valid
        reset = 1'b0;
        tick();
        chk("boot_pc", imem_pc, 32'h0000_3000);
        chk("boot_valid", {31'd0, id_valid}, 32'd0);

        // Sequential stream
        tick();
        chk("seq1_idpc", id_pc, 32'h0000_3000);
        chk("seq1_valid", {31'd0, id_valid}, 32'd1);
        chk("seq1_pc", imem_pc, 32'h0000_3004);
        chk("seq1_instr", id_instr, 32'h1111_1111);
        tick(); tick(); tick();
        chk("seq4_pc", imem_pc, 32'h0000_3010);
        chk("seq4_idpc", id_pc, 32'h0000_300C);
        chk("seq4_instr", id_instr, 32'h4444_4444);
        chk("seq4_pc8", id_pc8, 32'h0000_3014);

        // Re-reset; stall during BOOT must be ignored
        reset = 1'b1; tick(); reset = 1'b0;
        stall = 1'b1; tick();
        chk("bootstall_pc", imem_pc, 32'h0000_3000);
        stall = 1'b0; tick(); tick();
        chk("pre_br_idpc", id_pc, 32'h0000_3004);
        chk("pre_br_pc", imem_pc, 32'h0000_3008);

        // Backward branch, offset -1 word: target 0x3004, delay slot 0x3008
        npc_sel = 2'd1; br_off16 = 16'hFFFF;
        tick();
        chk("br_pc", imem_pc, 32'h0000_3004);
        chk("br_idpc", id_pc, 32'h0000_3008);
        chk("br_valid", {31'd0, id_valid}, 32'd1);
        chk("br_instr", id_instr, 32'h3333_3333);

        // Stall with pending jump: pure hold for 3 cycles
        stall = 1'b1; npc_sel = 2'd2; j_imm26 = 26'h0000C10;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_pc", imem_pc, 32'h0000_3004);
            chk("stall_idpc", id_pc, 32'h0000_3008);
        end
        stall = 1'b0;
        tick();
        chk("jmp_pc", imem_pc, 32'h0000_3040);
        chk("jmp_idpc", id_pc, 32'h0000_3004);
        chk("jmp_instr", id_instr, 32'h2222_2222);

        // Stalled would-be fault: nothing happens
        stall = 1'b1; npc_sel = 2'd3; jr_target = 32'h0000_3001;
        tick();
        chk("stallflt_fault", {31'd0, fault}, 32'd0);
        chk("stallflt_pc", imem_pc, 32'h0000_3040);

        // Misaligned jr faults
        stall = 1'b0;
        tick();
        chk("mis_fault", {31'd0, fault}, 32'd1);
        chk("mis_fpc", fault_pc, 32'h0000_3001);
        chk("mis_pc", imem_pc, 32'h0000_3040);
        chk("mis_idpc", id_pc, 32'h0000_3040);
        chk("mis_valid", {31'd0, id_valid}, 32'd1);
        npc_sel = 2'd0;
        tick();
        chk("halt_valid", {31'd0, id_valid}, 32'd0);
        chk("halt_instr", id_instr, 32'd0);
        chk("halt_fault", {31'd0, fault}, 32'd1);
        chk("halt_pc", imem_pc, 32'h0000_3040);
        chk("halt_fpc", fault_pc, 32'h0000_3001);

        // Reset clears the halt
        reset = 1'b1; tick();
        chk("clr_fault", {31'd0, fault}, 32'd0);
        chk("clr_pc", imem_pc, 32'h0000_3000);
        chk("clr_fpc", fault_pc, 32'd0);
        reset = 1'b0;

        // Range boundary: jr to last word is legal, run-off is not
        tick();
        npc_sel = 2'd3; jr_target = 32'h0000_3FFC;
        tick();
        chk("last_pc", imem_pc, 32'h0000_3FFC);
        chk("last_fault", {31'd0, fault}, 32'd0);
        npc_sel = 2'd0;
        tick();
        chk("end_idpc", id_pc, 32'h0000_3FFC);
        chk("end_instr", id_instr, 32'h4444_4400);
        chk("end_fault", {31'd0, fault}, 32'd1);
        chk("end_fpc", fault_pc, 32'h0000_4000);
        chk("end_pc", imem_pc, 32'h0000_3FFC);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Initiator side of the instruction-memory read interface: owns the PC, drives the word address into the combinational instruction ROM, and takes back the instruction word.
- Computes next-PC (sequential, branch, jump, jump-register) with MIPS delay-slot semantics.
- Registers the IF/ID pipeline stage, with stall and a sticky fetch-fault halt.
- Sits at the front of the pipelined CPU, between the instruction memory and the decode stage.

Parameters:
- PC_RESET, 32'h0000_3000, boot PC and base of legal code range.
- ADRBITS, 10, instruction ROM index width; legal range is [PC_RESET, PC_RESET + 4*2^ADRBITS).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hold PC and IF/ID stage.
- npc_sel  in  2  0 sequential, 1 branch, 2 jump imm26, 3 jump register.
- br_off16  in  16  branch offset of the instruction in ID.
- j_imm26  in  26  jump index of the instruction in ID.
- jr_target  in  32  register jump target.
- imem_pc  out  32  PC to instruction memory; memory indexes imem_pc[ADRBITS+1:2].
- imem_instr  in  32  instruction word returned combinationally.
- id_instr  out  32  IF/ID instruction.
- id_pc  out  32  IF/ID PC.
- id_pc8  out  32  id_pc + 8, link address.
- id_valid  out  1  IF/ID holds a real instruction.
- fault  out  1  sticky fetch fault.
- fault_pc  out  32  offending target address.

Behaviour:
- Reset (synchronous, wins over everything):
  - imem_pc = PC_RESET; id_instr = 0 (nop); id_pc = PC_RESET; id_valid = 0; fault = 0; fault_pc = 0; state = BOOT.
- State BOOT:
  - One cycle; PC held, id_valid stays 0.
  - Next edge goes to RUN; stall is ignored in BOOT.
- State RUN, at each edge in priority order:
  - stall = 1: PC and all IF/ID registers hold. npc_sel is ignored, because the ID-stage decision is not final while stalled.
  - npc_sel != 0: target is computed, then imem_pc <= target. IF/ID captures {imem_instr, imem_pc}, which is the delay slot; id_valid <= 1. No flush.
  - npc_sel = 0: imem_pc <= imem_pc + 4; IF/ID captures {imem_instr, imem_pc}; id_valid <= 1.
- Target arithmetic (32-bit, wraps mod 2^32):
  - branch = id_pc + 4 + (sign-extended br_off16 << 2).
  - jump = {id_pc[31:28] + carry-free from (id_pc + 4)[31:28], j_imm26, 2'b00}, i.e. the upper nibble is taken from (id_pc + 4).
  - jr = jr_target unchanged.
- Fault detection:
  - Applies to the next PC (sequential or redirected) on an unstalled RUN edge.
  - Fault if next[1:0] != 0, or next < PC_RESET, or next >= PC_RESET + 4*2^ADRBITS.
  - On fault: imem_pc holds; IF/ID still captures the current instruction (id_valid <= 1); fault <= 1; fault_pc <= next; state <= HALT.
  - Sequential run-off past the last word is also a fault.
- State HALT:
  - imem_pc frozen; id_instr <= 0; id_valid <= 0 from the first HALT edge onward.
  - fault and fault_pc hold; only reset exits.
- Simultaneous events:
  - reset during stall, redirect, or HALT: reset wins.
  - stall + npc_sel != 0: pure hold.
  - stall + would-be fault: no fault is raised.
- id_pc8 is combinational from id_pc.
- Outputs are registered except imem_pc, which is the PC register itself.

Test Plan:
- Reset/boot:
  - Assert reset 2 cycles, then release.
  - Required: imem_pc = 0x00003000 and id_valid = 0 through BOOT.
  - After the next edge: id_pc = 0x00003000, id_valid = 1, imem_pc = 0x00003004.
- Sequential stream:
  - ROM words 0x11111111 … at 0x3000…; run 4 RUN edges with npc_sel = 0.
  - Required: imem_pc = 0x00003010, id_pc = 0x0000300C, id_instr = ROM[3].
- Backward branch:
  - With id_pc = 0x00003004, drive npc_sel = 1, br_off16 = 0xFFFF.
  - Required: imem_pc = 0x00003004, id_pc = 0x00003008 (delay slot captured), id_valid = 1.
- Stall with redirect:
  - Hold stall = 1, npc_sel = 2, j_imm26 = 0x0000C10 for 3 cycles.
  - Required: imem_pc and IF/ID unchanged.
  - On the first unstalled edge: imem_pc = 0x00003040.
- Misaligned jr:
  - Drive npc_sel = 3, jr_target = 0x00003001.
  - Required: fault = 1, fault_pc = 0x00003001, imem_pc unchanged; next edge id_valid = 0, id_instr = 0.
  - reset clears fault to 0 and imem_pc to 0x00003000.
- Range boundary (ADRBITS = 10):
  - Sequential fetch at 0x00003FFC.
  - Required: id_pc = 0x00003FFC captured, fault = 1, fault_pc = 0x00004000.
  - Separately, jr to 0x00003FFC gives no fault.
